// File: rtl/biss_slave_emu.sv
// BiSS-C slave emulator: answers master clock MA with Ack/Start/CDS/data/nE,nW/~CRC6 then timeout.
// Optional multiturn field enabled by defining BISS_MULTITURN_EN (adds mt_in, sent ahead of ST bits).
module biss_slave_emu #(
  parameter int ST_BITS     = 26,
  parameter int ACK_CYC     = 2,
  parameter int TIMEOUT_CYC = 4000,
  parameter int MT_BITS     = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ma,
  input  logic [ST_BITS-1:0] pos_in,
  input  logic [1:0]         err_n_in,
`ifdef BISS_MULTITURN_EN
  input  logic [MT_BITS-1:0] mt_in,
`endif
  output logic               slo,
  output logic               busy,
  output logic               frame_done,
  output logic               abort
);

`ifdef BISS_MULTITURN_EN
  localparam int D_BITS = MT_BITS + ST_BITS;
`else
  localparam int D_BITS = ST_BITS;
`endif
  localparam int SR_W = D_BITS + 2;
  localparam int BC_W = $clog2(SR_W + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_START, S_CDS, S_DATA, S_ERR, S_CRC, S_TMO
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      ma_q;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [5:0]      crc_q, crc_d;
  logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]      ack_cnt_q, ack_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            slo_q, slo_d, busy_q, busy_d, done_q, done_d, abort_q, abort_d;

  logic       ma_fall, ma_rise, ma_edge, to_expired, tx_bit;
  logic [5:0] crc_upd;
  logic [SR_W-1:0] snap;

`ifdef BISS_MULTITURN_EN
  assign snap = {mt_in, pos_in, err_n_in};
`else
  assign snap = {pos_in, err_n_in};
`endif

  // ma_q[0..1] synchronise, ma_q[2] is the delay tap used for edge detection
  assign ma_fall    = ma_q[2] & ~ma_q[1];
  assign ma_rise    = ~ma_q[2] & ma_q[1];
  assign ma_edge    = ma_fall | ma_rise;
  assign to_expired = ~ma_edge && (to_cnt_q >= TO_W'(TIMEOUT_CYC - 1));
  assign tx_bit     = sr_q[SR_W-1];
  assign crc_upd    = {crc_q[4:0], 1'b0} ^ ((crc_q[5] ^ tx_bit) ? 6'h03 : 6'h00);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    crc_d     = crc_q;
    bit_cnt_d = bit_cnt_q;
    ack_cnt_d = ack_cnt_q;
    slo_d     = slo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    if (ma_edge)
      to_cnt_d = '0;
    else if (to_cnt_q != TO_W'(TIMEOUT_CYC))
      to_cnt_d = to_cnt_q + 1'b1;
    else
      to_cnt_d = to_cnt_q;

    case (state_q)
      S_IDLE: begin
        slo_d  = 1'b1;
        busy_d = 1'b0;
        if (ma_fall) begin
          sr_d      = snap;
          crc_d     = '0;
          ack_cnt_d = '0;
          busy_d    = 1'b1;
          slo_d     = 1'b0;
          state_d   = S_ACK;
        end
      end
      S_ACK: if (ma_rise) begin
        if (ack_cnt_q == 4'(ACK_CYC - 1)) begin
          slo_d   = 1'b1;
          state_d = S_START;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      S_START: if (ma_rise) begin
        slo_d   = 1'b0;
        state_d = S_CDS;
      end
      // data and error bits share one shift register and counter
      S_CDS, S_DATA, S_ERR: if (ma_rise) begin
        if (state_q == S_ERR && bit_cnt_q == BC_W'(SR_W)) begin
          slo_d     = ~crc_q[5];
          crc_d     = {crc_q[4:0], 1'b0};
          bit_cnt_d = BC_W'(1);
          state_d   = S_CRC;
        end else begin
          slo_d     = tx_bit;
          sr_d      = {sr_q[SR_W-2:0], 1'b0};
          crc_d     = crc_upd;
          bit_cnt_d = (state_q == S_CDS) ? BC_W'(1) : bit_cnt_q + 1'b1;
          if (state_q == S_CDS)
            state_d = (D_BITS == 0) ? S_ERR : S_DATA;
          else if (bit_cnt_q == BC_W'(D_BITS))
            state_d = S_ERR;
        end
      end
      S_CRC: if (ma_rise) begin
        if (bit_cnt_q == BC_W'(6)) begin
          slo_d   = 1'b0;
          state_d = S_TMO;
        end else begin
          slo_d     = ~crc_q[5];
          crc_d     = {crc_q[4:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_TMO: begin
        slo_d = 1'b0;
        if (to_expired && ma_q[1]) begin
          slo_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // master went quiet mid-frame
    if (state_q != S_IDLE && state_q != S_TMO && to_expired) begin
      slo_d   = 1'b1;
      busy_d  = 1'b0;
      abort_d = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ma_q      <= '1;
      sr_q      <= '0;
      crc_q     <= '0;
      bit_cnt_q <= '0;
      ack_cnt_q <= '0;
      to_cnt_q  <= '0;
      slo_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ma_q      <= {ma_q[1:0], ma};
      sr_q      <= sr_d;
      crc_q     <= crc_d;
      bit_cnt_q <= bit_cnt_d;
      ack_cnt_q <= ack_cnt_d;
      to_cnt_q  <= to_cnt_d;
      slo_q     <= slo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  assign slo        = slo_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_biss_slave_emu.sv
// Bench for biss_slave_emu: acts as BiSS master, predicts each SLO bit from a frame-level model.
module tb_biss_slave_emu;
  localparam int ST  = 26;
  localparam int ACK = 2;
  localparam int TMO = 200;
  localparam int MT  = 12;
`ifdef BISS_MULTITURN_EN
  localparam int DB = ST + MT;
`else
  localparam int DB = ST;
`endif

  logic          clk = 1'b0, rst = 1'b1, ma = 1'b1;
  logic [ST-1:0] pos_in = '0;
  logic [1:0]    err_n_in = 2'b11;
  logic [MT-1:0] mt_in = '0;
  wire           slo, busy, frame_done, abort;

  int checks = 0, failures = 0;
  bit done_ok = 1'b0, abort_ok = 1'b0, tog_en = 1'b0;

  biss_slave_emu #(.ST_BITS(ST), .ACK_CYC(ACK), .TIMEOUT_CYC(TMO), .MT_BITS(MT)) dut (
    .clk(clk), .rst(rst), .ma(ma), .pos_in(pos_in), .err_n_in(err_n_in),
`ifdef BISS_MULTITURN_EN
    .mt_in(mt_in),
`endif
    .slo(slo), .busy(busy), .frame_done(frame_done), .abort(abort));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic half(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [5:0] crc6(input bit d[$]);
    logic [5:0] c = '0;
    foreach (d[i]) c = {c[4:0], 1'b0} ^ ((c[5] ^ d[i]) ? 6'h03 : 6'h00);
    return c;
  endfunction

  task automatic toggler();
    while (tog_en) begin
      @(negedge clk);
      if (tog_en) begin
        pos_in   = ~pos_in;
        err_n_in = ~err_n_in;
      end
    end
  endtask

  // pulses are only legal inside the window the master sequence opens for them
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      checks++;
      if ((frame_done && !done_ok) || (abort && !abort_ok)) begin
        failures++;
        $display("FAIL pulse_unexpected done=%0b abort=%0b", frame_done, abort);
      end
    end
  end

  // q: per-rise expected SLO; stop_at: index after which MA stays high; rst_at: index to reset after
  task automatic run_frame(input int h, input int stop_at, input int rst_at, input bit tog);
    bit p[$];
    bit q[$];
    logic [5:0] c;
    int el;
    bit found;
`ifdef BISS_MULTITURN_EN
    for (int b = MT - 1; b >= 0; b--) p.push_back(mt_in[b]);
`endif
    for (int b = ST - 1; b >= 0; b--) p.push_back(pos_in[b]);
    p.push_back(err_n_in[1]);
    p.push_back(err_n_in[0]);
    c = crc6(p);
    repeat (ACK - 1) q.push_back(1'b0);
    q.push_back(1'b1);
    q.push_back(1'b0);
    foreach (p[j]) q.push_back(p[j]);
    for (int b = 5; b >= 0; b--) q.push_back(~c[b]);
    q.push_back(1'b0);

    @(negedge clk);
    ma = 1'b0;
    half(h);
    chk("start_busy", busy, 1);
    chk("ack_slo", slo, 0);
    if (tog) begin
      tog_en = 1'b1;
      fork toggler(); join_none
    end
    el = 0;
    for (int i = 0; i < q.size(); i++) begin
      ma = 1'b1;
      half(h);
      el = h;
      chk($sformatf("slo_bit%0d", i), slo, q[i]);
      chk($sformatf("busy_bit%0d", i), busy, 1);
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_slo", slo, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        half(3);
        rst = 1'b0;
        half(3);
        return;
      end
      if (i == stop_at || i == q.size() - 1) break;
      ma = 1'b0;
      half(h);
    end
    tog_en = 1'b0;

    found = 1'b0;
    if (stop_at >= 0) begin
      abort_ok = 1'b1;
      for (int k = 0; k < TMO + 20 && !found; k++) begin
        @(negedge clk);
        el++;
        if (abort) found = 1'b1;
      end
      chk("abort_seen", found, 1);
    end else begin
      done_ok = 1'b1;
      for (int k = 0; k < TMO + 20 && !found; k++) begin
        @(negedge clk);
        el++;
        if (frame_done) found = 1'b1;
        else chk("tmo_slo", slo, 0);
      end
      chk("done_seen", found, 1);
    end
    if (found) begin
      chk("end_latency", (el >= TMO && el <= TMO + 6), 1);
      chk("end_slo", slo, 1);
      chk("end_busy", busy, 0);
      @(negedge clk);
      chk("pulse_width", frame_done | abort, 0);
    end
    done_ok  = 1'b0;
    abort_ok = 1'b0;
    half(4);
    chk("idle_slo", slo, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    bit z[$];
    half(3);
    chk("rst_slo0", slo, 1);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", frame_done, 0);
    chk("rst_abort0", abort, 0);
    rst = 1'b0;
    half(5);
    chk("idle0_slo", slo, 1);

    // hand-computed CRC pins for the model
    repeat (ST) z.push_back(1'b0);
    z.push_back(1'b1); z.push_back(1'b1);
    chk("model_crc_11", crc6(z), 6'h05);
    z[ST] = 1'b0; z[ST+1] = 1'b0;
    chk("model_crc_00", crc6(z), 6'h00);

    mt_in = 12'h001; pos_in = '0; err_n_in = 2'b11;
    run_frame(6, -1, -1, 1'b0);
    err_n_in = 2'b00;
    run_frame(5, -1, -1, 1'b0);
    pos_in = 26'h2AAAAAA; err_n_in = 2'b10;
    run_frame(7, -1, -1, 1'b1);

    pos_in = ST'($urandom); err_n_in = 2'($urandom); mt_in = MT'($urandom);
    run_frame(6, ACK - 1 + 2 + 9, -1, 1'b0);
    run_frame(6, -1, -1, 1'b0);

    pos_in = ST'($urandom); err_n_in = 2'($urandom);
    run_frame(6, -1, ACK - 1 + 2 + DB + 2 + 2, 1'b0);
    chk("post_rst_slo", slo, 1);
    run_frame(5, -1, -1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      pos_in = ST'($urandom); err_n_in = 2'($urandom); mt_in = MT'($urandom);
      run_frame(int'($urandom_range(5, 9)), -1, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
